// File: rtl/light_hash_pkg.sv
// ============================================================================
// Module  : light_hash_pkg
// Brief   : Shared types, constants and byte functions for the light-hash core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package light_hash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [63:0] IV_DEFAULT = 64'h34550F14DAC02BEE;

    localparam logic [7:0] C_DIGIT_LO = 8'h30;
    localparam logic [7:0] C_DIGIT_HI = 8'h39;
    localparam logic [7:0] C_UPPER_LO = 8'h41;
    localparam logic [7:0] C_UPPER_HI = 8'h5A;
    localparam logic [7:0] C_LOWER_LO = 8'h61;
    localparam logic [7:0] C_LOWER_HI = 8'h7A;

    function automatic logic is_alnum(input logic [7:0] ch);
        return ((ch >= C_DIGIT_LO) && (ch <= C_DIGIT_HI)) ||
               ((ch >= C_UPPER_LO) && (ch <= C_UPPER_HI)) ||
               ((ch >= C_LOWER_LO) && (ch <= C_LOWER_HI));
    endfunction

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    // Inverse as x^254 (0 maps to 0), then the AES affine transform
    function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

`default_nettype wire

// File: rtl/light_hash_round.sv
// ============================================================================
// Module  : light_hash_round
// Brief   : One combinational light-hash round: chain of eight S-box updates.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module light_hash_round
    import light_hash_pkg::*;
(
    input  logic [63:0] h_in,
    input  logic [7:0]  m,
    output logic [63:0] h_out
);

    logic [7:0] w_b [8];

    // Bytes update in order, so bytes 6 and 7 read the already-updated 0 and 1
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_b[i] = h_in[63-8*i -: 8];
        end
        for (int i = 0; i < 8; i++) begin
            w_b[i] = aes128_sbox(8'((w_b[(i+2)%8] ^ m) << i));
        end
        h_out = 64'h0;
        for (int i = 0; i < 8; i++) begin
            h_out[63-8*i -: 8] = w_b[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/light_hash_ctrl.sv
// ============================================================================
// Module  : light_hash_ctrl
// Brief   : Message sequencer: absorbs alphanumeric chars, publishes digest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module light_hash_ctrl
    import light_hash_pkg::*;
#(
    parameter int unsigned ROUNDS = 32,
    parameter logic [63:0] IV     = IV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ptxt_char,
    input  logic        ptxt_last,
    input  logic        ptxt_valid,
    output logic        ptxt_ready,
    output logic        busy,
    output logic [63:0] digest,
    output logic        digest_valid,
    output logic        err_invalid_ptxt_char
);

    localparam logic [7:0] C_LAST_ROUND = 8'(ROUNDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_h;
    logic [7:0]  r_m;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic [63:0] r_digest;
    logic        r_digest_valid;
    logic        r_err;

    logic [63:0] w_round_out;
    logic        w_accept;
    logic        w_char_ok;
    logic        w_final_round;

    assign ptxt_ready            = (r_state == IDLE) || (r_state == FLUSH);
    assign busy                  = (r_state == ROUND);
    assign w_accept              = ptxt_valid && ptxt_ready;
    assign w_char_ok             = is_alnum(ptxt_char);
    assign w_final_round         = (r_cnt == C_LAST_ROUND);
    assign digest                = r_digest;
    assign digest_valid          = r_digest_valid;
    assign err_invalid_ptxt_char = r_err;

    light_hash_round u_round (
        .h_in  (r_h),
        .m     (r_m),
        .h_out (w_round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_char_ok)      w_state_next = ROUND;
                    else if (ptxt_last) w_state_next = IDLE;
                    else                w_state_next = FLUSH;
                end
            end
            ROUND: begin
                if (w_final_round) w_state_next = IDLE;
            end
            FLUSH: begin
                if (w_accept && ptxt_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h            <= IV;
            r_m            <= 8'h00;
            r_last         <= 1'b0;
            r_cnt          <= 8'h00;
            r_digest       <= 64'h0;
            r_digest_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            r_err          <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_char_ok) begin
                            r_m    <= ptxt_char;
                            r_last <= ptxt_last;
                            r_cnt  <= 8'h00;
                        end else begin
                            // A bad char poisons the whole message; restart from IV
                            r_err <= 1'b1;
                            r_h   <= IV;
                        end
                    end
                end
                ROUND: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_final_round && r_last) begin
                        r_digest       <= w_round_out;
                        r_digest_valid <= 1'b1;
                        r_h            <= IV;
                    end else begin
                        r_h <= w_round_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_light_hash_ctrl.sv
// ============================================================================
// Module  : tb_light_hash_ctrl
// Brief   : Self-checking bench for light_hash_ctrl with a digest scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_light_hash_ctrl;

    localparam int          ROUNDS = 32;
    localparam logic [63:0] IV     = 64'h34550F14DAC02BEE;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ptxt_char;
    logic        ptxt_last;
    logic        ptxt_valid;
    logic        ptxt_ready;
    logic        busy;
    logic [63:0] digest;
    logic        digest_valid;
    logic        err_invalid_ptxt_char;
    logic [63:0] rnd_in;
    logic [7:0]  rnd_m;
    logic [63:0] rnd_out;

    int          n_pass = 0;
    int          n_total = 0;
    int          obs_dv = 0;
    int          obs_err = 0;
    int          exp_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [63:0] exp_q [$];
    logic [63:0] h_model;
    bit          flushing;

    typedef struct {
        logic [7:0] ch;
        int         err;
        int         dv;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    light_hash_ctrl #(.ROUNDS(ROUNDS), .IV(IV)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ptxt_char             (ptxt_char),
        .ptxt_last             (ptxt_last),
        .ptxt_valid            (ptxt_valid),
        .ptxt_ready            (ptxt_ready),
        .busy                  (busy),
        .digest                (digest),
        .digest_valid          (digest_valid),
        .err_invalid_ptxt_char (err_invalid_ptxt_char)
    );

    light_hash_round u_rnd (
        .h_in  (rnd_in),
        .m     (rnd_m),
        .h_out (rnd_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [63:0] mdl_round(input logic [63:0] h, input logic [7:0] m);
        logic [7:0]  b [8];
        logic [63:0] r;
        for (int i = 0; i < 8; i++) b[i] = h[63-8*i -: 8];
        for (int i = 0; i < 8; i++) b[i] = SBOX[8'((b[(i+2)%8] ^ m) << i)];
        r = 64'h0;
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic logic [63:0] mdl_str(input string s);
        logic [63:0] h;
        h = IV;
        for (int i = 0; i < s.len(); i++)
            for (int r = 0; r < ROUNDS; r++) h = mdl_round(h, s.getc(i));
        return h;
    endfunction

    function automatic bit alnum_m(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    task automatic model_char(input logic [7:0] c, input logic l);
        if (flushing) begin
            if (l) flushing = 1'b0;
        end else if (alnum_m(c)) begin
            for (int r = 0; r < ROUNDS; r++) h_model = mdl_round(h_model, c);
            if (l) begin
                exp_q.push_back(h_model);
                h_model = IV;
            end
        end else begin
            h_model = IV;
            exp_err++;
            if (!l) flushing = 1'b1;
        end
    endtask

    // Drive one char, wait for the accepting edge; returns 1ns after it
    task automatic send(input logic [7:0] c, input logic l, input bit hold);
        int k;
        model_char(c, l);
        @(negedge clk);
        ptxt_char  = c;
        ptxt_last  = l;
        ptxt_valid = 1'b1;
        k = 0;
        while (!ptxt_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ptxt_ready) begin
            n_total++;
            $display("FAIL ready_timeout: ready=0 after %0d cycles, required 1", k);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) ptxt_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (digest_valid) begin
            obs_dv++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_digest_valid: got digest %0h, required no pulse", digest);
            end else begin
                chk("digest_scoreboard", digest, exp_q.pop_front());
            end
        end
        if (err_invalid_ptxt_char) obs_err++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int d0, e0, low, dvk, t0, t1;
        logic [63:0] first;

        vecs[0]  = '{"0", 0, 1};  vecs[1]  = '{"9", 0, 1};
        vecs[2]  = '{"A", 0, 1};  vecs[3]  = '{"Z", 0, 1};
        vecs[4]  = '{"a", 0, 1};  vecs[5]  = '{"z", 0, 1};
        vecs[6]  = '{"/", 1, 0};  vecs[7]  = '{":", 1, 0};
        vecs[8]  = '{"@", 1, 0};  vecs[9]  = '{"[", 1, 0};
        vecs[10] = '{8'h60, 1, 0}; vecs[11] = '{"{", 1, 0};

        rst_n = 1'b0; ptxt_valid = 1'b0; ptxt_char = 8'h00; ptxt_last = 1'b0;
        h_model = IV; flushing = 1'b0;

        rnd_in = IV; rnd_m = 8'h00; #1;
        chk("rnd_byte0", {56'h0, rnd_out[63:56]}, 64'h76);
        chk("rnd_byte1", {56'h0, rnd_out[55:48]}, 64'h34);
        chk("rnd_full_m00", rnd_out, mdl_round(IV, 8'h00));
        rnd_m = 8'h41; #1;
        chk("rnd_full_m41", rnd_out, mdl_round(IV, 8'h41));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_digest", digest, 64'h0);
        chk("rst_dv", {63'h0, digest_valid}, 64'h0);
        chk("rst_err", {63'h0, err_invalid_ptxt_char}, 64'h0);
        chk("rst_ready", {63'h0, ptxt_ready}, 64'h1);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // Single 'A': latency and repeatability
        d0 = obs_dv;
        send("A", 1'b1, 1'b0);
        low = 0; dvk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!ptxt_ready) low++;
            if (digest_valid && dvk == 0) dvk = k;
        end
        chk("A_ready_low_cycles", 64'(low), 64'd32);
        chk("A_dv_latency", 64'(dvk), 64'd33);
        chk("A_dv_pulses", 64'(obs_dv - d0), 64'd1);
        chk("A_digest", digest, mdl_str("A"));
        first = digest;
        send("A", 1'b1, 1'b0);
        repeat (ROUNDS + 4) @(negedge clk);
        chk("A_repeat_same", digest, first);

        // Boundary characters as single-char messages
        for (int i = 0; i < 12; i++) begin
            d0 = obs_dv; e0 = obs_err;
            send(vecs[i].ch, 1'b1, 1'b0);
            repeat (ROUNDS + 4) @(negedge clk);
            chk($sformatf("bnd_err_%02h", vecs[i].ch), 64'(obs_err - e0), 64'(vecs[i].err));
            chk($sformatf("bnd_dv_%02h", vecs[i].ch), 64'(obs_dv - d0), 64'(vecs[i].dv));
        end

        // "ab#cd": rejected mid-message, rest flushed
        d0 = obs_dv; e0 = obs_err;
        send("a", 1'b0, 1'b1);
        send("b", 1'b0, 1'b1);
        send("#", 1'b0, 1'b1);
        send("c", 1'b0, 1'b1);
        chk("flush_busy_c", {63'h0, busy}, 64'h0);
        chk("flush_ready_c", {63'h0, ptxt_ready}, 64'h1);
        send("d", 1'b1, 1'b0);
        chk("flush_busy_d", {63'h0, busy}, 64'h0);
        repeat (ROUNDS + 4) @(negedge clk);
        chk("flush_err_pulses", 64'(obs_err - e0), 64'd1);
        chk("flush_dv_pulses", 64'(obs_dv - d0), 64'd0);
        d0 = obs_dv;
        send("a", 1'b0, 1'b1);
        send("b", 1'b1, 1'b0);
        repeat (ROUNDS + 4) @(negedge clk);
        chk("ab_dv_pulses", 64'(obs_dv - d0), 64'd1);
        chk("ab_digest", digest, mdl_str("ab"));

        // Reset at round 10 of a char
        send("Q", 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_digest", digest, 64'h0);
        chk("midrst_dv", {63'h0, digest_valid}, 64'h0);
        chk("midrst_err", {63'h0, err_invalid_ptxt_char}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_ready", {63'h0, ptxt_ready}, 64'h1);
        exp_q.delete(); h_model = IV; flushing = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        d0 = obs_dv;
        send("H", 1'b0, 1'b1);
        send("i", 1'b1, 1'b0);
        repeat (ROUNDS + 4) @(negedge clk);
        chk("postrst_dv_pulses", 64'(obs_dv - d0), 64'd1);
        chk("postrst_digest", digest, mdl_str("Hi"));

        // Back-to-back "Xy9" with valid held high
        d0 = obs_dv;
        send("X", 1'b0, 1'b1); t0 = acc_cyc;
        send("y", 1'b0, 1'b1); t1 = acc_cyc;
        chk("b2b_spacing_1", 64'(t1 - t0), 64'(ROUNDS + 1));
        send("9", 1'b1, 1'b0);
        chk("b2b_spacing_2", 64'(acc_cyc - t1), 64'(ROUNDS + 1));
        repeat (ROUNDS + 4) @(negedge clk);
        chk("b2b_dv_pulses", 64'(obs_dv - d0), 64'd1);
        chk("b2b_digest", digest, mdl_str("Xy9"));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("err_total", 64'(obs_err), 64'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
